// File: rtl/sha_pkg.sv
// rtl/sha_pkg.sv - shared constants and types for the SHA-256 message block sequencer
package sha_pkg;

  localparam int MAX_MSG_LENGTH_DEFAULT = 55;
  localparam int BLOCK_W                = 512;
  localparam logic [7:0] PAD_BYTE       = 8'h80;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    DRAIN,
    PAD,
    VALID
  } msg_seq_state_t;

  // Bit offset of the LSB of byte k; byte 0 sits at the top of the block
  function automatic logic [8:0] byte_lsb(input logic [5:0] k);
    return {6'd63 - k, 3'b000};
  endfunction

endpackage

// File: rtl/msg_block_sequencer.sv
// rtl/msg_block_sequencer.sv - builds one padded SHA-256 block from message SRAM
module msg_block_sequencer
  import sha_pkg::*;
#(
  parameter int MAX_MSG_LENGTH = MAX_MSG_LENGTH_DEFAULT,
  parameter int ADDR_W         = $clog2(MAX_MSG_LENGTH),
  parameter int LEN_W          = $clog2(MAX_MSG_LENGTH + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [LEN_W-1:0]   msg_len,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_read_en,
  input  logic [7:0]         mem_data,
  output logic               busy,
  output logic               block_valid,
  input  logic               block_ready,
  output logic [BLOCK_W-1:0] message_block,
  output logic               done,
  output logic               error
);

  msg_seq_state_t     r_state;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_rd_ptr;
  logic               r_rd_pend;
  logic               r_block_valid;
  logic               r_error;
  logic [BLOCK_W-1:0] r_block;

  logic [5:0]         w_wr_byte;
  logic               w_accept;

  // Read data belongs to the address issued one cycle earlier
  assign w_wr_byte     = 6'(r_rd_ptr - LEN_W'(1));
  assign w_accept      = r_block_valid & block_ready;

  assign mem_read_en   = (r_state == READ);
  assign mem_addr      = mem_read_en ? r_rd_ptr[ADDR_W-1:0] : '0;
  assign busy          = (r_state != IDLE);
  assign block_valid   = r_block_valid;
  assign message_block = r_block;
  assign done          = w_accept;
  assign error         = r_error;

  // Sequencer FSM: fetch bytes, drain the last read, pad, then hold until accepted
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_len         <= '0;
      r_rd_ptr      <= '0;
      r_rd_pend     <= 1'b0;
      r_block_valid <= 1'b0;
      r_error       <= 1'b0;
      r_block       <= '0;
    end else begin
      r_error   <= 1'b0;
      r_rd_pend <= 1'b0;
      if (r_rd_pend) begin
        r_block[byte_lsb(w_wr_byte) +: 8] <= mem_data;
      end
      case (r_state)
        IDLE: begin
          if (start) begin
            if (msg_len > LEN_W'(MAX_MSG_LENGTH)) begin
              r_error <= 1'b1;
            end else begin
              r_len    <= msg_len;
              r_block  <= '0;
              r_rd_ptr <= '0;
              if (msg_len == '0) begin
                r_state <= PAD;
              end else begin
                r_state <= READ;
              end
            end
          end
        end
        READ: begin
          r_rd_pend <= 1'b1;
          r_rd_ptr  <= r_rd_ptr + LEN_W'(1);
          if (r_rd_ptr == r_len - LEN_W'(1)) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          r_state <= PAD;
        end
        PAD: begin
          r_block[byte_lsb(6'(r_len)) +: 8] <= PAD_BYTE;
          r_block[63:0]                     <= 64'(r_len) << 3;
          r_state                           <= VALID;
        end
        VALID: begin
          if (w_accept) begin
            r_block_valid <= 1'b0;
            r_state       <= IDLE;
          end else begin
            r_block_valid <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msg_block_sequencer.sv
// tb/tb_msg_block_sequencer.sv - scoreboard bench for msg_block_sequencer
module tb_msg_block_sequencer;

  logic         clock;
  logic         reset;
  logic         start;
  logic [5:0]   msg_len;
  logic [5:0]   mem_addr;
  logic         mem_read_en;
  logic [7:0]   mem_data;
  logic         busy;
  logic         block_valid;
  logic         block_ready;
  logic [511:0] message_block;
  logic         done;
  logic         error;

  logic [7:0]   mem [0:63];
  logic [511:0] sb_q [$];
  int           n_checks;
  int           n_fail;

  msg_block_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .msg_len(msg_len),
    .mem_addr(mem_addr), .mem_read_en(mem_read_en), .mem_data(mem_data),
    .busy(busy), .block_valid(block_valid), .block_ready(block_ready),
    .message_block(message_block), .done(done), .error(error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous-read SRAM model
  always @(posedge clock) begin
    if (mem_read_en) mem_data <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] build_block(input int len);
    logic [511:0] b;
    b = '0;
    for (int k = 0; k < len; k++) b[511-8*k -: 8] = mem[k];
    b[511-8*len -: 8] = 8'h80;
    b[63:0] = 64'(len * 8);
    return b;
  endfunction

  task automatic run_msg(input int len, input int hold, input bit poke_start);
    logic [511:0] exp_blk;
    int n_reads, n_done, valid_cycles, lat;
    bit finished;
    exp_blk = build_block(len);
    sb_q.push_back(exp_blk);
    n_reads = 0; n_done = 0; valid_cycles = 0; lat = -1; finished = 0;
    @(negedge clock); start = 1'b1; msg_len = 6'(len);
    @(posedge clock);
    for (int c = 0; c < 200 && !finished; c++) begin
      @(negedge clock); start = 1'b0; block_ready = 1'b0;
      if (mem_read_en) begin
        check("addr", 512'(mem_addr), 512'(n_reads));
        check("read_cycle", 512'(c), 512'(n_reads));
        n_reads++;
      end
      if (block_valid) begin
        if (lat < 0) begin
          lat = c;
          check("latency", 512'(c), 512'((len == 0) ? 2 : len + 3));
        end
        check("blk_stable", message_block, exp_blk);
        if (poke_start && valid_cycles == 2) begin start = 1'b1; msg_len = 6'd3; end
        if (valid_cycles >= hold) begin
          block_ready = 1'b1;
          #1;
          check("done", 512'(done), 512'(1));
          check("sb_pending", 512'(sb_q.size()), 512'(1));
          if (sb_q.size() != 0) check("block", message_block, sb_q.pop_front());
          finished = 1;
        end else begin
          #1;
          check("done_early", 512'(done), 512'(0));
        end
        valid_cycles++;
      end
    end
    if (!finished) check("timeout", 512'(finished), 512'(1));
    check("read_count", 512'(n_reads), 512'(len));
    @(negedge clock); start = 1'b0;
    check("done_once", 512'(done), 512'(0));
    check("valid_drop", 512'(block_valid), 512'(0));
    check("idle_busy", 512'(busy), 512'(0));
    block_ready = 1'b0;
  endtask

  initial begin
    logic [511:0] exp0;
    bit hit;
    n_checks = 0; n_fail = 0;
    reset = 1'b0; start = 1'b0; msg_len = '0; block_ready = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clock);
    check("rst_busy", 512'(busy), 512'(0));
    check("rst_valid", 512'(block_valid), 512'(0));
    check("rst_rden", 512'(mem_read_en), 512'(0));
    check("rst_addr", 512'(mem_addr), 512'(0));
    check("rst_block", message_block, 512'(0));
    check("rst_err", 512'(error), 512'(0));
    reset = 1'b1;

    mem[0] = 8'h61; mem[1] = 8'h62; mem[2] = 8'h63;
    run_msg(3, 0, 1'b0);
    check("abc_hi", 512'(message_block[511:480]), 512'(32'h61626380));
    check("abc_mid", 512'(message_block[479:64]), 512'(0));
    check("abc_len", 512'(message_block[63:0]), 512'(64'h18));

    run_msg(0, 0, 1'b0);
    exp0 = '0; exp0[511:504] = 8'h80;
    check("len0_blk", message_block, exp0);

    for (int i = 0; i < 64; i++) mem[i] = 8'(i);
    run_msg(55, 1, 1'b0);
    check("len55_b54", 512'(message_block[511-8*54 -: 8]), 512'(8'h36));
    check("len55_b55", 512'(message_block[511-8*55 -: 8]), 512'(8'h80));
    check("len55_len", 512'(message_block[63:0]), 512'(64'h1B8));

    for (int i = 0; i < 7; i++) mem[i] = 8'($urandom_range(0, 255));
    run_msg(7, 10, 1'b1);

    @(negedge clock); start = 1'b1; msg_len = 6'd56;
    @(posedge clock);
    @(negedge clock); start = 1'b0;
    check("err_pulse", 512'(error), 512'(1));
    check("err_busy", 512'(busy), 512'(0));
    check("err_rden", 512'(mem_read_en), 512'(0));
    @(negedge clock);
    check("err_clear", 512'(error), 512'(0));
    check("err_busy2", 512'(busy), 512'(0));
    check("err_rden2", 512'(mem_read_en), 512'(0));

    mem[0] = 8'h61; mem[1] = 8'h62; mem[2] = 8'h63; mem[3] = 8'h64; mem[4] = 8'h65;
    @(negedge clock); start = 1'b1; msg_len = 6'd5;
    @(posedge clock);
    hit = 0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clock); start = 1'b0;
      if (mem_read_en && mem_addr == 6'd2) hit = 1;
    end
    check("mid_read_hit", 512'(hit), 512'(1));
    reset = 1'b0;
    #1;
    check("mr_busy", 512'(busy), 512'(0));
    check("mr_rden", 512'(mem_read_en), 512'(0));
    check("mr_addr", 512'(mem_addr), 512'(0));
    check("mr_block", message_block, 512'(0));
    check("mr_valid", 512'(block_valid), 512'(0));
    @(negedge clock); reset = 1'b1;

    run_msg(3, 2, 1'b0);
    check("abc2_hi", 512'(message_block[511:480]), 512'(32'h61626380));
    check("abc2_len", 512'(message_block[63:0]), 512'(64'h18));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
